// File: rtl/wisc_pkg.sv
// ---------------------------------------------------------------------------
// wisc_pkg
// Shared definitions for the WISC-SP13 fetch-PC redirect logic:
//   - 5-bit opcode constants for the control-flow instructions
//   - redirect FSM state encoding (RUN / PEND / HALT)
//   - helper functions decoding jumps and branch conditions
// ---------------------------------------------------------------------------
package wisc_pkg;

    localparam int OPC_W = 5;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_BNEZ = 5'b01101;
    localparam logic [4:0] OP_BLTZ = 5'b01110;
    localparam logic [4:0] OP_BGEZ = 5'b01111;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_PEND = 2'b01,
        ST_HALT = 2'b10
    } pc_state_e;

    // Unconditional register/PC-relative jumps (SIIC/RTI handled separately).
    function automatic logic is_jump(input logic [4:0] op);
        logic j;
        case (op)
            OP_J, OP_JR, OP_JAL, OP_JALR: j = 1'b1;
            default:                      j = 1'b0;
        endcase
        return j;
    endfunction

    // Branch condition evaluated on the Rs flags; non-branches never take.
    function automatic logic branch_cond(input logic [4:0] op,
                                         input logic       z,
                                         input logic       p,
                                         input logic       n);
        logic c;
        case (op)
            OP_BEQZ: c = z;
            OP_BNEZ: c = p | n;
            OP_BLTZ: c = n;
            OP_BGEZ: c = p | z;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // Instructions that write the link register R7.
    function automatic logic is_link(input logic [4:0] op);
        logic l;
        case (op)
            OP_JAL, OP_JALR: l = 1'b1;
            default:         l = 1'b0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/pc_target_gen.sv
// ---------------------------------------------------------------------------
// pc_target_gen
// Combinational redirect-target arithmetic (all results mod 2^PC_W).
// Ports:
//   pc_ex_i      PC of resolving instruction
//   rs_val_i     Rs operand, base for JR/JALR
//   imm8_i       signed 8-bit branch / JR offset
//   disp11_i     signed 11-bit J/JAL displacement
//   seq_pc_o     pc_ex + 2 (also the R7 link value)
//   br_target_o  pc_ex + 2 + sext(imm8)
//   j_target_o   pc_ex + 2 + sext(disp11)
//   jr_target_o  rs_val + sext(imm8)
// ---------------------------------------------------------------------------
module pc_target_gen #(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] pc_ex_i,
    input  logic [PC_W-1:0] rs_val_i,
    input  logic [7:0]      imm8_i,
    input  logic [10:0]     disp11_i,
    output logic [PC_W-1:0] seq_pc_o,
    output logic [PC_W-1:0] br_target_o,
    output logic [PC_W-1:0] j_target_o,
    output logic [PC_W-1:0] jr_target_o
);

    localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-2){1'b0}}, 2'b10};

    logic [PC_W-1:0] imm_sext_s;
    logic [PC_W-1:0] disp_sext_s;

    assign imm_sext_s  = {{(PC_W-8){imm8_i[7]}}, imm8_i};
    assign disp_sext_s = {{(PC_W-11){disp11_i[10]}}, disp11_i};

    assign seq_pc_o    = pc_ex_i + PC_STEP;
    assign br_target_o = seq_pc_o + imm_sext_s;
    assign j_target_o  = seq_pc_o + disp_sext_s;
    assign jr_target_o = rs_val_i + imm_sext_s;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
// Fetch-PC sequencer for the WISC-SP13 pipeline: PC+2 stepping, branch and
// jump redirects, halt, and holding a redirect that meets a fetch stall.
// Optional feature macro: PC_CTRL_EPC_EN (SIIC saves EPC and vectors to
// VECTOR_PC, RTI returns to EPC). Without it SIIC/RTI behave as NOP.
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   stall           fetch stall, holds pc
//   valid_in        resolving instruction present this cycle
//   opcode          opcode of resolving instruction
//   pc_ex, rs_val   PC and Rs operand of resolving instruction
//   imm8, disp11    signed offsets
//   zero_flag, positive_flag, negative_flag   Rs flags for branches
//   pc              registered fetch PC
//   flush           kill younger fetched instruction (resolve cycle)
//   link_en         write link_val to R7 (JAL/JALR)
//   link_val        pc_ex + 2
//   halted          core halted
// ---------------------------------------------------------------------------
module pc_redirect_ctrl
    import wisc_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [PC_W-1:0] VECTOR_PC = 16'h0002
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            valid_in,
    input  logic [4:0]      opcode,
    input  logic [PC_W-1:0] pc_ex,
    input  logic [PC_W-1:0] rs_val,
    input  logic [7:0]      imm8,
    input  logic [10:0]     disp11,
    input  logic            zero_flag,
    input  logic            positive_flag,
    input  logic            negative_flag,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic            link_en,
    output logic [PC_W-1:0] link_val,
    output logic            halted
);

    localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-2){1'b0}}, 2'b10};

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic [PC_W-1:0] epc_s;

    logic [PC_W-1:0] seq_pc_s, br_target_s, j_target_s, jr_target_s;
    logic [PC_W-1:0] target_s;
    logic            jump_s;
    logic            taken_s;
    logic            halt_s;
    logic            save_epc_s;

    pc_target_gen #(.PC_W(PC_W)) u_target_gen (
        .pc_ex_i     (pc_ex),
        .rs_val_i    (rs_val),
        .imm8_i      (imm8),
        .disp11_i    (disp11),
        .seq_pc_o    (seq_pc_s),
        .br_target_o (br_target_s),
        .j_target_o  (j_target_s),
        .jr_target_o (jr_target_s)
    );

`ifdef PC_CTRL_EPC_EN
    logic [PC_W-1:0] epc_q;

    assign jump_s     = is_jump(opcode) | (opcode == OP_SIIC) | (opcode == OP_RTI);
    // EPC is captured only when the SIIC redirect is actually accepted.
    assign save_epc_s = (state_q == ST_RUN) & valid_in & (opcode == OP_SIIC);
    assign epc_s      = epc_q;

    // Exception PC register: return address for RTI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q <= {PC_W{1'b0}};
        end else if (save_epc_s) begin
            epc_q <= seq_pc_s;
        end else begin
            epc_q <= epc_q;
        end
    end
`else
    assign jump_s     = is_jump(opcode);
    assign save_epc_s = 1'b0;
    assign epc_s      = {PC_W{1'b0}};
`endif

    assign taken_s  = valid_in & (jump_s | branch_cond(opcode, zero_flag,
                                                       positive_flag, negative_flag));
    assign halt_s   = valid_in & (opcode == OP_HALT);
    assign link_val = seq_pc_s;
    assign pc       = pc_q;

    // Redirect target selection by opcode; only used when taken_s is set.
    always_comb begin
        target_s = br_target_s;
        case (opcode)
            OP_J, OP_JAL:    target_s = j_target_s;
            OP_JR, OP_JALR:  target_s = jr_target_s;
            OP_SIIC:         target_s = VECTOR_PC;
            OP_RTI:          target_s = epc_s;
            default:         target_s = br_target_s;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and pending-target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            pend_q <= {PC_W{1'b0}};
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
        end
    end

    // Next-state and next-PC logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        case (state_q)
            ST_RUN: begin
                if (taken_s) begin
                    if (stall) begin
                        // Redirect cannot be applied yet: park it until stall clears.
                        pend_d  = target_s;
                        state_d = ST_PEND;
                    end else begin
                        pc_d = target_s;
                    end
                end else if (halt_s) begin
                    state_d = ST_HALT;
                end else if (!stall) begin
                    pc_d = pc_q + PC_STEP;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_PEND: begin
                if (!stall) begin
                    pc_d    = pend_q;
                    state_d = ST_RUN;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_HALT: begin
                pc_d    = pc_q;
                state_d = ST_HALT;
            end
            default: begin
                // Illegal encoding: recover to RUN without moving the PC.
                state_d = ST_RUN;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        flush   = 1'b0;
        halted  = 1'b0;
        link_en = valid_in & is_link(opcode);
        case (state_q)
            ST_RUN: begin
                if (taken_s) begin
                    flush = 1'b1;
                end else begin
                    flush = 1'b0;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                flush  = 1'b0;
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl
// Directed-vector bench for pc_redirect_ctrl. Inputs change 1 time unit after
// the rising edge; combinational outputs are checked 1 unit later, registered
// outputs 1 unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;
    import wisc_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        valid_in;
    logic [4:0]  opcode;
    logic [15:0] pc_ex;
    logic [15:0] rs_val;
    logic [7:0]  imm8;
    logic [10:0] disp11;
    logic        zero_flag;
    logic        positive_flag;
    logic        negative_flag;
    logic [15:0] pc;
    logic        flush;
    logic        link_en;
    logic [15:0] link_val;
    logic        halted;

    int n_vec;
    int n_err;
    logic [15:0] exp_pc;

    pc_redirect_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .valid_in      (valid_in),
        .opcode        (opcode),
        .pc_ex         (pc_ex),
        .rs_val        (rs_val),
        .imm8          (imm8),
        .disp11        (disp11),
        .zero_flag     (zero_flag),
        .positive_flag (positive_flag),
        .negative_flag (negative_flag),
        .pc            (pc),
        .flush         (flush),
        .link_en       (link_en),
        .link_val      (link_val),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [15:0] pcx,
                         input logic [15:0] rs, input logic [7:0] imm, input logic [10:0] disp,
                         input logic z, input logic p, input logic n, input logic st);
        valid_in      = v;
        opcode        = op;
        pc_ex         = pcx;
        rs_val        = rs;
        imm8          = imm;
        disp11        = disp;
        zero_flag     = z;
        positive_flag = p;
        negative_flag = n;
        stall         = st;
    endtask

    task automatic idle(input logic st);
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0, st);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        idle(1'b0);
        #1;
        check_val("rst_pc", pc, 16'h0000);
        check_val("rst_halted", {15'd0, halted}, 16'h0000);
        check_val("rst_flush", {15'd0, flush}, 16'h0000);
        step();
        step();
        rst = 1'b0;
        check_val("rel_pc", pc, 16'h0000);

        // Sequential stepping
        for (int i = 1; i <= 4; i++) begin
            step();
            check_val("seq_pc", pc, 16'(2 * i));
            check_val("seq_flush", {15'd0, flush}, 16'h0000);
        end

        // BEQZ taken, backward
        drive(1'b1, OP_BEQZ, 16'h0010, 16'h0000, 8'hFC, 11'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check_val("beqz_t_flush", {15'd0, flush}, 16'h0001);
        step(); check_val("beqz_t_pc", pc, 16'h000E);
        // BEQZ not taken
        drive(1'b1, OP_BEQZ, 16'h0010, 16'h0000, 8'hFC, 11'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check_val("beqz_nt_flush", {15'd0, flush}, 16'h0000);
        step(); check_val("beqz_nt_pc", pc, 16'h0010);

        // JAL with negative displacement
        drive(1'b1, OP_JAL, 16'h0100, 16'h0000, 8'h00, 11'h7FE, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_val("jal_link_en", {15'd0, link_en}, 16'h0001);
        check_val("jal_link_val", link_val, 16'h0102);
        check_val("jal_flush", {15'd0, flush}, 16'h0001);
        step(); check_val("jal_pc", pc, 16'h0100);

        // BLTZ taken, BGEZ on negative not taken, BNEZ wrapping target
        drive(1'b1, OP_BLTZ, 16'h0020, 16'h0000, 8'h10, 11'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 check_val("bltz_flush", {15'd0, flush}, 16'h0001);
        step(); check_val("bltz_pc", pc, 16'h0032);
        drive(1'b1, OP_BGEZ, 16'h0030, 16'h0000, 8'h10, 11'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 check_val("bgez_nt_flush", {15'd0, flush}, 16'h0000);
        check_val("bgez_nt_link", {15'd0, link_en}, 16'h0000);
        step(); check_val("bgez_nt_pc", pc, 16'h0034);
        drive(1'b1, OP_BNEZ, 16'h0000, 16'h0000, 8'h80, 11'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check_val("bnez_flush", {15'd0, flush}, 16'h0001);
        step(); check_val("bnez_pc", pc, 16'hFF82);

        // Unknown opcode behaves as NOP
        drive(1'b1, 5'b11111, 16'h0000, 16'h1234, 8'h04, 11'h004, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 check_val("unk_flush", {15'd0, flush}, 16'h0000);
        step(); check_val("unk_pc", pc, 16'hFF84);

        // SIIC / RTI
        drive(1'b1, OP_SIIC, 16'h0040, 16'h0000, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
`ifdef PC_CTRL_EPC_EN
        check_val("siic_pc", pc, 16'h0002);
`else
        check_val("siic_pc", pc, 16'hFF86);
`endif
        idle(1'b0);
        step();
        drive(1'b1, OP_RTI, 16'h0080, 16'h0000, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
`ifdef PC_CTRL_EPC_EN
        check_val("rti_pc", pc, 16'h0042);
        exp_pc = 16'h0042;
`else
        check_val("rti_pc", pc, 16'hFF8A);
        exp_pc = 16'hFF8A;
`endif

        // Plain stall holds pc
        idle(1'b1);
        step(); check_val("stall_pc", pc, exp_pc);

        // JR redirect meeting a 3-cycle stall
        drive(1'b1, OP_JR, 16'h0300, 16'hFFFE, 8'h04, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 check_val("jr_flush", {15'd0, flush}, 16'h0001);
        step(); check_val("jr_pend_pc0", pc, exp_pc);
        // Instruction during PEND: ignored for redirect, still produces link
        drive(1'b1, OP_JALR, 16'h0200, 16'h0800, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check_val("pend_flush", {15'd0, flush}, 16'h0000);
        check_val("pend_link_en", {15'd0, link_en}, 16'h0001);
        check_val("pend_link_val", link_val, 16'h0202);
        step(); check_val("jr_pend_pc1", pc, exp_pc);
        idle(1'b1);
        step(); check_val("jr_pend_pc2", pc, exp_pc);
        idle(1'b0);
        step(); check_val("jr_release_pc", pc, 16'h0002);
        step(); check_val("post_jr_pc", pc, 16'h0004);

        // HALT freezes pc
        drive(1'b1, OP_HALT, 16'h0004, 16'h0000, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check_val("halt_flush", {15'd0, flush}, 16'h0000);
        step();
        check_val("halt_pc", pc, 16'h0004);
        check_val("halt_halted", {15'd0, halted}, 16'h0001);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, OP_J, 16'h0004, 16'h0000, 8'h00, 11'h010, 1'b0, 1'b0, 1'b0, i[0]);
            #1 check_val("halted_flush", {15'd0, flush}, 16'h0000);
            step();
            check_val("halted_pc", pc, 16'h0004);
            check_val("halted_flag", {15'd0, halted}, 16'h0001);
        end

        // Reset pulse exits HALT
        idle(1'b0);
        rst = 1'b1;
        #1;
        check_val("halt_rst_pc", pc, 16'h0000);
        check_val("halt_rst_halted", {15'd0, halted}, 16'h0000);
        step();
        rst = 1'b0;
        step(); check_val("after_rst_pc", pc, 16'h0002);

        // Reset during PEND drops the pending target
        drive(1'b1, OP_JR, 16'h0002, 16'h0100, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); check_val("pend2_pc", pc, 16'h0002);
        idle(1'b0);
        rst = 1'b1;
        #1 check_val("pend_rst_pc", pc, 16'h0000);
        step();
        rst = 1'b0;
        step(); check_val("pend_rst_next_pc", pc, 16'h0002);
        step(); check_val("pend_rst_next2_pc", pc, 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
